// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator
//
// Purpose: free-running pixel/line counters with registered blank, active-low
//          hs/vs, line/frame strobes and an 8-bit frame counter.
// Ports:   vga_clk     pixel clock
//          reset       asynchronous active-high reset
//          DrawX/DrawY current column/line (10 bit)
//          blank       1 = visible pixel
//          hs/vs       active-low syncs
//          line_start  pulse when DrawX == 0
//          frame_start pulse when DrawX == 0 && DrawY == 0
//          frame_cnt   frames started since reset (wraps)
// Option:  VGA_SYNC_DELAY_EN - hs/vs delayed by SYNC_DELAY extra stages.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 1) begin : g_bad_params
      $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY >= 1");
   end

   logic [9:0] next_x, next_y;
   logic       hs_raw, vs_raw;

   // Flags are derived from the next counter values so every registered
   // output describes the same pixel as DrawX/DrawY.
   always_comb begin
      next_x = DrawX;
      next_y = DrawY;
      if (DrawX == H_LAST) begin
         next_x = '0;
         next_y = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
      end else begin
         next_x = DrawX + 10'd1;
      end
   end

   // Reset parks the counters on the last pixel so the first edge lands on (0,0).
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         DrawX       <= H_LAST;
         DrawY       <= V_LAST;
         blank       <= 1'b0;
         hs_raw      <= 1'b1;
         vs_raw      <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 8'hFF;
      end else begin
         DrawX       <= next_x;
         DrawY       <= next_y;
         blank       <= (next_x < H_VIS) && (next_y < V_VIS);
         hs_raw      <= !((next_x >= HS_START) && (next_x < HS_END));
         // next_y only moves on the horizontal wrap, so vs is line-granular
         vs_raw      <= !((next_y >= VS_START) && (next_y < VS_END));
         line_start  <= (next_x == 10'd0);
         frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
         if ((next_x == 10'd0) && (next_y == 10'd0))
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   // Extra stages keep sync aligned with renderers that register ROM data and RGB.
   logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hs_pipe <= '1;
         vs_pipe <= '1;
      end else begin
         hs_pipe[0] <= hs_raw;
         vs_pipe[0] <= vs_raw;
         for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
         end
      end
   end

   assign hs = hs_pipe[SYNC_DELAY-1];
   assign vs = vs_pipe[SYNC_DELAY-1];
`else
   assign hs = hs_raw;
   assign vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   // small geometry for the long frame tests: 15 x 13 = 195 cycles/frame
   localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVV = 6, BVF = 2, BVS = 2, BVB = 3;
   localparam int BFR = (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB);

   logic       vga_clk = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic [9:0] x_a, y_a, x_b, y_b;
   logic       blank_a, hs_a, vs_a, ls_a, fs_a;
   logic       blank_b, hs_b, vs_b, ls_b, fs_b;
   logic [7:0] fc_a, fc_b;
   int         n_a, n_b;
   int         errors = 0;
   int         checks = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen u_dut_a (
      .vga_clk(vga_clk), .reset(rst_a), .DrawX(x_a), .DrawY(y_a), .blank(blank_a),
      .hs(hs_a), .vs(vs_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_timing_gen #(
      .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB), .SYNC_DELAY(2)
   ) u_dut_b (
      .vga_clk(vga_clk), .reset(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(blank_b),
      .hs(hs_b), .vs(vs_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
   );

   wire [32:0] obs_a = {x_a, y_a, blank_a, hs_a, vs_a, ls_a, fs_a, fc_a};
   wire [32:0] obs_b = {x_b, y_b, blank_b, hs_b, vs_b, ls_b, fs_b, fc_b};

   // edges since reset release, per instance
   always @(posedge vga_clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
   always @(posedge vga_clk or posedge rst_b) if (rst_b) n_b <= 0; else n_b <= n_b + 1;

   // Reference: raster position is just (edges-1) modulo the frame size.
   function automatic logic [32:0] model(input int n, input int hv, input int hf, input int hsy,
                                         input int hb, input int vv, input int vf, input int vsy,
                                         input int vb);
      int ht, vt, p, x, y, m, q, sx, sy;
      logic hsv, vsv;
      ht = hv + hf + hsy + hb;
      vt = vv + vf + vsy + vb;
      if (n == 0) return {10'(ht-1), 10'(vt-1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
      p = (n - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      m = n - SD;
      hsv = 1'b1;
      vsv = 1'b1;
      if (m > 0) begin
         q  = (m - 1) % (ht * vt);
         sx = q % ht;
         sy = q / ht;
         hsv = !(sx >= hv + hf && sx < hv + hf + hsy);
         vsv = !(sy >= vv + vf && sy < vv + vf + vsy);
      end
      return {10'(x), 10'(y), (x < hv) && (y < vv), hsv, vsv, x == 0, (x == 0) && (y == 0),
              8'((n - 1) / (ht * vt))};
   endfunction

   function automatic logic [32:0] exp_a(input int n);
      return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   function automatic logic [32:0] exp_b(input int n);
      return model(n, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
   endfunction

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (5) begin
         @(negedge vga_clk);
         checks++;
         if (obs_a !== exp_a(0)) begin
            errors++; $display("FAIL reset_hold_a: got %h want %h", obs_a, exp_a(0));
         end
         checks++;
         if (obs_b !== exp_b(0)) begin
            errors++; $display("FAIL reset_hold_b: got %h want %h", obs_b, exp_b(0));
         end
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      checks++;
      if (obs_a !== exp_a(0)) begin
         errors++; $display("FAIL release_hold_a: got %h want %h", obs_a, exp_a(0));
      end
      @(negedge vga_clk);
      checks++;
      if (obs_a !== exp_a(1)) begin
         errors++; $display("FAIL first_edge_a: got %h want %h", obs_a, exp_a(1));
      end
      checks++;
      if ({x_b, y_b, blank_b, fs_b, fc_b} !== {10'd0, 10'd0, 1'b1, 1'b1, 8'd0}) begin
         errors++; $display("FAIL first_edge_b: got %h", {x_b, y_b, blank_b, fs_b, fc_b});
      end
   endtask

   task automatic test_line();
      int   hs_fall = -1, hs_rise = -1, blank_fall = -1, ls_cnt = 0;
      logic prev_hs = 1'b1, prev_blank = 1'b1;
      for (int i = 0; i < 1600; i++) begin
         @(negedge vga_clk);
         checks++;
         if (obs_a !== exp_a(n_a)) begin
            errors++; $display("FAIL line_a n=%0d: got %h want %h", n_a, obs_a, exp_a(n_a));
         end
         if (prev_hs && !hs_a && hs_fall < 0) hs_fall = int'(x_a);
         if (!prev_hs && hs_a && hs_rise < 0) hs_rise = int'(x_a);
         if (prev_blank && !blank_a && blank_fall < 0) blank_fall = int'(x_a);
         if (ls_a) ls_cnt++;
         prev_hs = hs_a;
         prev_blank = blank_a;
      end
      checks++;
      if (hs_fall != 656 + SD) begin
         errors++; $display("FAIL hs_fall_x: got %0d want %0d", hs_fall, 656 + SD);
      end
      checks++;
      if (hs_rise != 752 + SD) begin
         errors++; $display("FAIL hs_rise_x: got %0d want %0d", hs_rise, 752 + SD);
      end
      checks++;
      if (blank_fall != 640) begin
         errors++; $display("FAIL blank_fall_x: got %0d want 640", blank_fall);
      end
      checks++;
      if (ls_cnt != 2) begin
         errors++; $display("FAIL line_start_count: got %0d want 2", ls_cnt);
      end
   endtask

   task automatic test_frames();
      int   fs_cnt = 0, vs_low = 0, hs_low = 0, last_fs = -1, period_err = 0;
      int   base = 0;
      logic saw_wrap = 1'b0;
      logic [7:0] prev_fc = 8'd0;
      for (int i = 0; i < 257 * BFR; i++) begin
         @(negedge vga_clk);
         checks++;
         if (obs_b !== exp_b(n_b)) begin
            errors++; $display("FAIL frame_b n=%0d: got %h want %h", n_b, obs_b, exp_b(n_b));
         end
         checks++;
         if (obs_a !== exp_a(n_a)) begin
            errors++; $display("FAIL frame_a n=%0d: got %h want %h", n_a, obs_a, exp_a(n_a));
         end
         if (!vs_b) vs_low++;
         if (!hs_b) hs_low++;
         if (fs_b) begin
            if (fs_cnt == 0) base = int'(fc_b);
            checks++;
            if (fc_b !== 8'((base + fs_cnt) % 256)) begin
               errors++; $display("FAIL frame_cnt_seq: got %0d want %0d", fc_b, (base + fs_cnt) % 256);
            end
            if (fs_cnt > 0 && prev_fc == 8'd255 && fc_b == 8'd0) saw_wrap = 1'b1;
            if (last_fs >= 0 && i - last_fs != BFR) period_err++;
            last_fs = i;
            prev_fc = fc_b;
            fs_cnt++;
         end
      end
      checks++;
      if (fs_cnt != 257) begin
         errors++; $display("FAIL frame_start_count: got %0d want 257", fs_cnt);
      end
      checks++;
      if (period_err != 0) begin
         errors++; $display("FAIL frame_period: got %0d bad periods want 0", period_err);
      end
      checks++;
      if (!saw_wrap) begin
         errors++; $display("FAIL frame_cnt_wrap: got no 255->0 wrap want one");
      end
      checks++;
      if (vs_low != 257 * BVS * (BHV+BHF+BHS+BHB)) begin
         errors++; $display("FAIL vs_low_cycles: got %0d want %0d", vs_low, 257 * BVS * (BHV+BHF+BHS+BHB));
      end
      checks++;
      if (hs_low != 257 * BHS * (BVV+BVF+BVS+BVB)) begin
         errors++; $display("FAIL hs_low_cycles: got %0d want %0d", hs_low, 257 * BHS * (BVV+BVF+BVS+BVB));
      end
   endtask

   task automatic test_mid_reset();
      for (int r = 0; r < 3; r++) begin
         int tpos, waited;
         tpos = int'($urandom_range(16, BFR - 5));
         waited = 0;
         while (((n_b - 1) % BFR) != tpos && waited < 2 * BFR) begin
            @(negedge vga_clk);
            waited++;
         end
         checks++;
         if (((n_b - 1) % BFR) != tpos) begin
            errors++; $display("FAIL mid_reset_reach: got pos %0d want %0d", (n_b - 1) % BFR, tpos);
         end
         #2;
         rst_b = 1'b1;
         #1;
         checks++;
         if (obs_b !== exp_b(0)) begin
            errors++; $display("FAIL mid_reset_async: got %h want %h", obs_b, exp_b(0));
         end
         repeat ($urandom_range(1, 4)) begin
            @(negedge vga_clk);
            checks++;
            if (obs_b !== exp_b(0)) begin
               errors++; $display("FAIL mid_reset_hold: got %h want %h", obs_b, exp_b(0));
            end
         end
         rst_b = 1'b0;
         for (int i = 0; i < 2 * BFR; i++) begin
            @(negedge vga_clk);
            checks++;
            if (obs_b !== exp_b(n_b)) begin
               errors++; $display("FAIL restart_b n=%0d: got %h want %h", n_b, obs_b, exp_b(n_b));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frames();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
